// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline control chain.
//   CNT_W / CNT_MAX : width and saturation value of the event counters
//   ctrl_fields_t   : typical 16-bit control payload layout (opcode, funct3,
//                     wb_sel, write enables)
//   sat_inc()       : saturating increment used by both counters
package pipe_ctrl_pkg;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
        logic [6:0] opcode;
    } ctrl_fields_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage -- one register stage of the control chain.
//   clk, rst            : clock, async active-high reset
//   i_flush             : kill this stage (highest priority)
//   i_hold              : keep current contents
//   i_bubble            : upstream is held, so load an empty slot
//   i_prev_valid/data   : contents of the previous stage (or pipe input)
//   o_valid/o_data      : stage contents; data is zero whenever invalid
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic             i_prev_valid,
    input  logic [WIDTH-1:0] i_prev_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= i_prev_valid;
                // invalid payload is squashed so empty stages read as zero
                r_data  <= i_prev_valid ? i_prev_data : '0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain -- DEPTH-stage control pipeline with per-stage stall/flush
// and saturating stall/flush event counters.
//   clk, rst           : clock, async active-high reset
//   in_valid/in_data   : upstream payload; in_ready = stage 0 can accept
//   stall[i], flush[i] : per-stage hold and kill requests
//   cnt_clr            : synchronous clear of both counters
//   stage_valid        : valid bit of every stage
//   out_valid/out_data : last stage contents
//   stall_cnt          : cycles with hold[0]=1 (saturating)
//   flush_cnt          : cycles where a flush hit a valid stage (saturating)
module pipe_ctrl_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [DEPTH-1:0] stall,
    input  logic [DEPTH-1:0] flush,
    input  logic             cnt_clr,
    output logic [DEPTH-1:0] stage_valid,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DEPTH-1:0]            w_hold;
    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_data;
    logic [CNT_W-1:0]            r_stall_cnt;
    logic [CNT_W-1:0]            r_flush_cnt;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            // a stall anywhere downstream freezes this stage too
            if (g == DEPTH - 1) begin : g_hold_last
                assign w_hold[g] = stall[g];
            end else begin : g_hold_mid
                assign w_hold[g] = stall[g] | w_hold[g+1];
            end

            if (g == 0) begin : g_first
                pipe_ctrl_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk         (clk),
                    .rst         (rst),
                    .i_flush     (flush[g]),
                    .i_hold      (w_hold[g]),
                    .i_bubble    (1'b0),
                    .i_prev_valid(in_valid),
                    .i_prev_data (in_data),
                    .o_valid     (w_valid[g]),
                    .o_data      (w_data[g])
                );
            end else begin : g_next
                // held upstream + free this stage => bubble enters here
                pipe_ctrl_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk         (clk),
                    .rst         (rst),
                    .i_flush     (flush[g]),
                    .i_hold      (w_hold[g]),
                    .i_bubble    (w_hold[g-1]),
                    .i_prev_valid(w_valid[g-1]),
                    .i_prev_data (w_data[g-1]),
                    .o_valid     (w_valid[g]),
                    .o_data      (w_data[g])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hold[0])
                r_stall_cnt <= sat_inc(r_stall_cnt);
            // one count per cycle regardless of how many stages were hit
            if (|(flush & w_valid))
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign in_ready    = ~w_hold[0];
    assign stage_valid = w_valid;
    assign out_valid   = w_valid[DEPTH-1];
    assign out_data    = w_data[DEPTH-1];
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
module tb_pipe_ctrl_chain;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [D-1:0] stall;
    logic [D-1:0] flush;
    logic         cnt_clr;
    logic [D-1:0] stage_valid;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  stall_cnt;
    logic [15:0]  flush_cnt;

    int nvec = 0;
    int nerr = 0;
    logic chk_en = 1'b0;

    pipe_ctrl_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .stage_valid(stage_valid),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slot-array view of the pipe: a stage is frozen if any stall bit at or
    // beyond it is set; it becomes empty if only upstream is frozen.
    logic [D-1:0] m_v;
    logic [W-1:0] m_d [D];
    logic [15:0]  m_sc, m_fc;

    function automatic logic frozen(input int i, input logic [D-1:0] st);
        return (st >> i) != '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v  <= '0;
            for (int i = 0; i < D; i++) m_d[i] <= '0;
            m_sc <= '0;
            m_fc <= '0;
        end else begin
            if (flush[0]) begin
                m_v[0] <= 1'b0; m_d[0] <= '0;
            end else if (!frozen(0, stall)) begin
                m_v[0] <= in_valid; m_d[0] <= in_valid ? in_data : '0;
            end
            for (int i = 1; i < D; i++) begin
                if (flush[i]) begin
                    m_v[i] <= 1'b0; m_d[i] <= '0;
                end else if (!frozen(i, stall)) begin
                    if (frozen(i - 1, stall)) begin
                        m_v[i] <= 1'b0; m_d[i] <= '0;
                    end else begin
                        m_v[i] <= m_v[i-1]; m_d[i] <= m_v[i-1] ? m_d[i-1] : '0;
                    end
                end
            end
            if (cnt_clr) begin
                m_sc <= '0;
                m_fc <= '0;
            end else begin
                if (stall != '0 && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
                if ((flush & m_v) != '0 && m_fc != 16'hFFFF) m_fc <= m_fc + 16'd1;
            end
        end
    end

    // compare every cycle, mid-period
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stage_valid", 32'(stage_valid), 32'(m_v));
            chk("out_valid",   32'(out_valid),   32'(m_v[D-1]));
            chk("out_data",    32'(out_data),    32'(m_d[D-1]));
            chk("in_ready",    32'(in_ready),    32'(stall == '0));
            chk("stall_cnt",   32'(stall_cnt),   32'(m_sc));
            chk("flush_cnt",   32'(flush_cnt),   32'(m_fc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cyc();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        stall = '0; flush = '0; cnt_clr = 1'b0;
        #1;
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_cnts",  32'({stall_cnt, flush_cnt}), 32'h0);
        chk_en = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // three back-to-back inputs, out on edges 3,4,5
        feed(8'h11); feed(8'h22); feed(8'h33);
        in_valid = 1'b0;
        chk("lat_e3", 32'({out_valid, out_data}), 32'h111);
        cyc();
        chk("lat_e4", 32'({out_valid, out_data}), 32'h122);
        cyc();
        chk("lat_e5", 32'({out_valid, out_data}), 32'h133);
        chk("lat_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);

        // full pipe, stall last stage two cycles
        feed(8'hA1); feed(8'hA2); feed(8'hA3);
        stall = 3'b100; in_valid = 1'b1; in_data = 8'hB1;
        #1;
        chk("stall_rdy", 32'(in_ready), 32'h0);
        cyc(); cyc();
        chk("stall_hold", 32'({stage_valid, out_data}), 32'h7A1);
        chk("stall_cnt2", 32'(stall_cnt), 32'd2);
        stall = '0; in_valid = 1'b0;
        cyc();
        chk("drain_a2", 32'({out_valid, out_data}), 32'h1A2);
        cyc();
        chk("drain_a3", 32'({out_valid, out_data}), 32'h1A3);

        // stall stage 0 with pipe full: bubble at stage 1
        feed(8'hC1); feed(8'hC2); feed(8'hC3);
        stall = 3'b001; in_data = 8'hC4;
        cyc();
        chk("bub_sv1", 32'(stage_valid[1]), 32'h0);
        chk("bub_out", 32'({out_valid, out_data}), 32'h1C2);
        stall = '0; in_valid = 1'b0;
        cyc();
        chk("bub_gap", 32'(out_valid), 32'h0);
        cyc();
        chk("bub_c3", 32'({out_valid, out_data}), 32'h1C3);

        // flush stage 1 while stage 2 stalled
        feed(8'hD1); feed(8'hD2); feed(8'hD3);
        in_valid = 1'b0; flush = 3'b010; stall = 3'b100;
        cyc();
        chk("fl_sv", 32'(stage_valid), 32'b101);
        chk("fl_cnt", 32'(flush_cnt), 32'd1);
        chk("fl_hold", 32'({out_valid, out_data}), 32'h1D1);
        flush = '0; stall = '0;
        cyc();
        chk("fl_zero", 32'({out_valid, out_data}), 32'h000);
        cyc(); cyc();

        // flush stage 0 on an accepted input; empty pipe so no flush count
        flush = 3'b001; in_valid = 1'b1; in_data = 8'hE1;
        cyc();
        flush = '0; in_valid = 1'b0;
        chk("fl0_sv", 32'(stage_valid), 32'h0);
        chk("fl0_cnt", 32'(flush_cnt), 32'd1);
        cyc(); cyc(); cyc();

        // saturation, then clear with stall still asserted
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("clr0", 32'({stall_cnt, flush_cnt}), 32'h0);
        stall = 3'b100;
        repeat (65540) cyc();
        chk("sat", 32'(stall_cnt), 32'hFFFF);
        cnt_clr = 1'b1;
        cyc();
        chk("clr_pri", 32'(stall_cnt), 32'h0);
        cnt_clr = 1'b0; stall = '0;

        // async reset with pipe full
        feed(8'hF1); feed(8'hF2); feed(8'hF3);
        in_valid = 1'b0; stall = 3'b100;
        cyc();
        chk("pre_rst", 32'({out_valid, stall_cnt}), 32'h10001);
        rst = 1'b1;
        #1;
        chk("arst_out", 32'({out_valid, out_data}), 32'h0);
        chk("arst_sv", 32'(stage_valid), 32'h0);
        chk("arst_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);
        rst = 1'b0; stall = '0;
        feed(8'h5A);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("post_rst", 32'({out_valid, out_data}), 32'h15A);
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the payload bits carried per stage (legal 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages (legal 1..8).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream payload (control fields: opcode, funct3, wb_sel, write enables).
REQ-008 The block SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-009 The block SHALL have port stall  input  DEPTH  per-stage stall request, bit i = stage i.
REQ-010 The block SHALL have port flush  input  DEPTH  per-stage kill request, bit i = stage i.
REQ-011 The block SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-012 The block SHALL have port stage_valid  output  DEPTH  valid bit of each stage.
REQ-013 The block SHALL have port out_valid  output  1  valid of stage DEPTH-1.
REQ-014 The block SHALL have port out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-015 The block SHALL have port stall_cnt  output  16  saturating count of cycles with hold[0]=1.
REQ-016 The block SHALL have port flush_cnt  output  16  saturating count of cycles with any flush bit set on a valid stage.

Function
REQ-017 The block SHALL compute hold[i] = OR of stall[j] for j >= i (a downstream stall freezes all upstream stages).
REQ-018 The block SHALL drive in_ready = ~hold[0], combinationally.
REQ-019 Per stage, per clock edge, priority SHALL be: flush[i] -> valid 0, data 0; else hold[i] -> keep valid and data; else hold[i-1] -> bubble (valid 0, data 0); else load from stage i-1 (stage -1 = in_valid/in_data).
REQ-020 Bubble insertion SHALL occur only at stage i+1 when stall[i]=1 and hold[i+1]=0; payload SHALL never be duplicated or dropped except by flush.
REQ-021 An input with in_valid=1 and in_ready=1 SHALL appear on out_data/out_valid exactly DEPTH edges later if no hold or flush intervenes.
REQ-022 Data of any invalid stage SHALL be all-zero.
REQ-023 flush and stall on the same stage in the same cycle SHALL resolve to flush.
REQ-024 flush[0] with an accepted input SHALL discard that input.
REQ-025 stall_cnt SHALL increment on each edge where hold[0]=1, and saturate at 0xFFFF.
REQ-026 flush_cnt SHALL increment by 1 (not per bit) on each edge where (flush & stage_valid) != 0, and saturate at 0xFFFF.
REQ-027 cnt_clr SHALL zero both counters on the next edge, taking priority over any increment in the same cycle.
REQ-028 With DEPTH=1, hold[0]=stall[0], and the bubble rule SHALL not apply.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force all stage_valid, stage data, out_valid, out_data, stall_cnt and flush_cnt to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight payload; the first accepted input after deassertion SHALL follow REQ-021.

Structure
REQ-031 The shared package pipe_ctrl_pkg SHALL hold CNT_W=16 and CNT_MAX=16'hFFFF, plus a packed control-field struct for typical WIDTH use.
REQ-032 One stage SHALL be the sub-module pipe_ctrl_stage (inputs: flush, hold, bubble, prev valid/data), instantiated DEPTH times in a generate loop.

Verification (WIDTH=8, DEPTH=3)
REQ-033 Reset then inputs 0x11,0x22,0x33 on consecutive cycles SHALL produce out_data 0x11,0x22,0x33 with out_valid=1 on edges 3,4,5, counters 0.
REQ-034 Full pipe with stall=3'b100 for 2 cycles SHALL hold all stages, give in_ready=0, and leave stall_cnt=2 with no payload lost.
REQ-035 stall=3'b001 for one cycle with stages full SHALL give stage_valid[1]=0 on the next edge and a single-cycle gap in out_valid.
REQ-036 flush=3'b010 and stall=3'b100 in the same cycle SHALL clear stage 1 (valid 0, data 0x00), hold stage 2, and give flush_cnt=1.
REQ-037 stall[2]=1 held for 65540 cycles SHALL give stall_cnt=0xFFFF; cnt_clr=1 with stall[2]=1 still asserted SHALL give stall_cnt=0 on the next edge.
REQ-038 rst asserted between edges with the pipe full SHALL zero out_valid, out_data and both counters before the next clk edge.
